// File: rtl/wb_mbox_pkg.sv
// Shared definitions for the Wishbone mailbox: register offsets, STATUS/CTRL bit positions
// and the decoded register select type.
package wb_mbox_pkg;

    localparam logic [1:0] REG_DATA    = 2'b00;
    localparam logic [1:0] REG_STATUS  = 2'b01;
    localparam logic [1:0] REG_CTRL    = 2'b10;
    localparam logic [1:0] REG_SCRATCH = 2'b11;

    localparam int ST_TX_EMPTY     = 0;
    localparam int ST_TX_FULL      = 1;
    localparam int ST_RX_EMPTY     = 2;
    localparam int ST_RX_FULL      = 3;
    localparam int ST_TX_COUNT_LSB = 8;
    localparam int ST_RX_COUNT_LSB = 16;

    localparam int CTRL_IRQ_EN = 0;
    localparam int CTRL_FLUSH  = 1;

    typedef enum logic [1:0] {
        SEL_DATA    = REG_DATA,
        SEL_STATUS  = REG_STATUS,
        SEL_CTRL    = REG_CTRL,
        SEL_SCRATCH = REG_SCRATCH
    } mbox_reg_e;

    function automatic mbox_reg_e decode_reg(input logic [1:0] adr_word);
        return mbox_reg_e'(adr_word);
    endfunction

endpackage

// File: rtl/mbox_fifo.sv
// First-word-fall-through FIFO with push/pop/flush and an occupancy count (0..DEPTH).
// DEPTH must be a power of two so the pointers wrap naturally.
module mbox_fifo #(
    parameter  int DEPTH = 8,
    parameter  int WIDTH = 32,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    input  logic             flush,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rd_data = mem[rd_ptr];

    // NOTE: storage is deliberately not reset; pointers and count alone decide which entries are live.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // NOTE: all state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/wb_mailbox_slave.sv
// Wishbone B3 classic mailbox slave: DATA writes feed the TX stream, DATA reads drain the RX stream.
// Optional interrupt output is built when MBOX_IRQ_EN is defined.
module wb_mailbox_slave
    import wb_mbox_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int ADDR_W     = 32
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_ni,
    input  logic [ADDR_W-1:0] wb_adr_i,
    input  logic [31:0]       wb_dat_i,
    input  logic [3:0]        wb_sel_i,
    input  logic              wb_cyc_i,
    input  logic              wb_stb_i,
    input  logic              wb_we_i,
    output logic [31:0]       wb_dat_o,
    output logic              wb_ack_o,
    output logic              wb_err_o,
    output logic              wb_rty_o,
    output logic [31:0]       m_data_o,
    output logic              m_valid_o,
    input  logic              m_ready_i,
    input  logic [31:0]       s_data_i,
    input  logic              s_valid_i,
    output logic              s_ready_o
`ifdef MBOX_IRQ_EN
    ,
    output logic              irq_o
`endif
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic             tx_full, tx_empty, tx_push;
    logic             rx_full, rx_empty, rx_pop, rx_push;
    logic [CNT_W-1:0] tx_count, rx_count;
    logic [31:0]      rx_data;
    logic             flush, ctrl_we, scratch_we, access_ok, req;
    logic             irq_en, ready_en;
    logic [31:0]      scratch, status, rd_data;
    mbox_reg_e        reg_sel;
    logic             unused_adr;

    assign unused_adr = ^{wb_adr_i[ADDR_W-1:4], wb_adr_i[1:0]};
    assign reg_sel    = decode_reg(wb_adr_i[3:2]);
    // A new access is only sampled when the previous termination has been seen.
    assign req        = wb_cyc_i & wb_stb_i & ~wb_ack_o & ~wb_err_o;
    assign wb_rty_o   = 1'b0;
    assign m_valid_o  = ~tx_empty;
    assign s_ready_o  = ready_en & ~rx_full;
    assign rx_push    = s_valid_i & s_ready_o;

    always_comb begin
        status                                = '0;
        status[ST_TX_EMPTY]                   = tx_empty;
        status[ST_TX_FULL]                    = tx_full;
        status[ST_RX_EMPTY]                   = rx_empty;
        status[ST_RX_FULL]                    = rx_full;
        status[ST_TX_COUNT_LSB +: 8]          = 8'(tx_count);
        status[ST_RX_COUNT_LSB +: 8]          = 8'(rx_count);
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        access_ok  = 1'b1;
        tx_push    = 1'b0;
        rx_pop     = 1'b0;
        flush      = 1'b0;
        ctrl_we    = 1'b0;
        scratch_we = 1'b0;
        rd_data    = '0;
        unique case (reg_sel)
            SEL_DATA: begin
                if (wb_we_i) begin
                    access_ok = (wb_sel_i == 4'hF) && !tx_full;
                    tx_push   = req && access_ok;
                end else begin
                    access_ok = !rx_empty;
                    rx_pop    = req && access_ok;
                    rd_data   = rx_data;
                end
            end
            SEL_STATUS: begin
                access_ok = !wb_we_i;
                rd_data   = status;
            end
            SEL_CTRL: begin
                ctrl_we = req && wb_we_i;
                flush   = ctrl_we && wb_sel_i[0] && wb_dat_i[CTRL_FLUSH];
                rd_data = {31'b0, irq_en};
            end
            SEL_SCRATCH: begin
                scratch_we = req && wb_we_i;
                rd_data    = scratch;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            wb_ack_o <= 1'b0;
            wb_err_o <= 1'b0;
            wb_dat_o <= '0;
            irq_en   <= 1'b0;
            scratch  <= '0;
            ready_en <= 1'b0;
        end else begin
            wb_ack_o <= req & access_ok;
            wb_err_o <= req & ~access_ok;
            wb_dat_o <= (req && access_ok && !wb_we_i) ? rd_data : '0;
            ready_en <= 1'b1;
            if (ctrl_we && wb_sel_i[0]) irq_en <= wb_dat_i[CTRL_IRQ_EN];
            for (int b = 0; b < 4; b++) begin
                if (scratch_we && wb_sel_i[b]) scratch[8*b +: 8] <= wb_dat_i[8*b +: 8];
            end
        end
    end

`ifdef MBOX_IRQ_EN
    logic irq_q;
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) irq_q <= 1'b0;
        else            irq_q <= irq_en & ~rx_empty;
    end
    assign irq_o = irq_q;
`endif

    mbox_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(32)) u_tx_fifo (
        .clk     (wb_clk_i),
        .rst_n   (wb_rst_ni),
        .push    (tx_push),
        .wr_data (wb_dat_i),
        .pop     (m_valid_o & m_ready_i),
        .rd_data (m_data_o),
        .flush   (flush),
        .full    (tx_full),
        .empty   (tx_empty),
        .count   (tx_count)
    );

    mbox_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(32)) u_rx_fifo (
        .clk     (wb_clk_i),
        .rst_n   (wb_rst_ni),
        .push    (rx_push),
        .wr_data (s_data_i),
        .pop     (rx_pop),
        .rd_data (rx_data),
        .flush   (flush),
        .full    (rx_full),
        .empty   (rx_empty),
        .count   (rx_count)
    );

endmodule

// File: tb/tb_wb_mailbox_slave.sv
// Self-checking bench for wb_mailbox_slave: register vector table plus stream/FIFO corner sequences.
// Define MBOX_IRQ_EN for both bench and RTL to exercise the interrupt output.
`timescale 1ns/1ps
module tb_wb_mailbox_slave;

    localparam int          ADDR_W    = 32;
    localparam logic [31:0] A_DATA    = 32'h0;
    localparam logic [31:0] A_STATUS  = 32'h4;
    localparam logic [31:0] A_CTRL    = 32'h8;
    localparam logic [31:0] A_SCRATCH = 32'hC;

    logic              clk      = 1'b0;
    logic              rst_n    = 1'b0;
    logic [ADDR_W-1:0] wb_adr   = '0;
    logic [31:0]       wb_dat_w = '0;
    logic [3:0]        wb_sel   = '0;
    logic              wb_cyc   = 1'b0;
    logic              wb_stb   = 1'b0;
    logic              wb_we    = 1'b0;
    logic [31:0]       wb_dat_r;
    logic              wb_ack, wb_err, wb_rty;
    logic [31:0]       m_data;
    logic              m_valid;
    logic              m_ready  = 1'b0;
    logic [31:0]       s_data   = '0;
    logic              s_valid  = 1'b0;
    logic              s_ready;
`ifdef MBOX_IRQ_EN
    logic              irq;
`endif

    typedef struct {
        string       name;
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic        err;
        logic [31:0] rdat;
    } vec_t;

    typedef struct {
        logic        err;
        logic        chk_dat;
        logic [31:0] dat;
    } exp_t;

    vec_t        vecs[$];
    exp_t        exp_q[$];
    logic [31:0] tx_q[$];
    logic [31:0] rx_q[$];
    int          n_cmp  = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    wb_mailbox_slave #(.FIFO_DEPTH(8), .ADDR_W(ADDR_W)) dut (
        .wb_clk_i  (clk),
        .wb_rst_ni (rst_n),
        .wb_adr_i  (wb_adr),
        .wb_dat_i  (wb_dat_w),
        .wb_sel_i  (wb_sel),
        .wb_cyc_i  (wb_cyc),
        .wb_stb_i  (wb_stb),
        .wb_we_i   (wb_we),
        .wb_dat_o  (wb_dat_r),
        .wb_ack_o  (wb_ack),
        .wb_err_o  (wb_err),
        .wb_rty_o  (wb_rty),
        .m_data_o  (m_data),
        .m_valid_o (m_valid),
        .m_ready_i (m_ready),
        .s_data_i  (s_data),
        .s_valid_i (s_valid),
        .s_ready_o (s_ready)
`ifdef MBOX_IRQ_EN
        ,
        .irq_o     (irq)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    task automatic add_vec(input string name, input logic we, input logic [31:0] adr,
                           input logic [31:0] dat, input logic [3:0] sel,
                           input logic err, input logic [31:0] rdat);
        vec_t v;
        v.name = name; v.we = we; v.adr = adr; v.dat = dat; v.sel = sel; v.err = err; v.rdat = rdat;
        vecs.push_back(v);
    endtask

    // One complete bus access; returns one idle cycle after termination.
    task automatic bus_xfer(input string name, input logic we, input logic [31:0] adr,
                            input logic [31:0] dat, input logic [3:0] sel,
                            input logic exp_err, input logic [31:0] exp_rdat);
        exp_t e;
        int   n;
        logic done;
        e.err     = exp_err;
        e.chk_dat = !we;
        e.dat     = exp_err ? 32'h0 : exp_rdat;
        exp_q.push_back(e);
        if (we && adr[3:2] == 2'b00 && !exp_err) tx_q.push_back(dat);
        wb_adr = adr; wb_dat_w = dat; wb_sel = sel; wb_we = we; wb_cyc = 1'b1; wb_stb = 1'b1;
        n = 0;
        done = 1'b0;
        while (!done && n < 8) begin
            @(posedge clk); #1;
            n++;
            done = wb_ack | wb_err;
        end
        e = exp_q.pop_front();
        if (!done) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s_timeout: got no ack/err in %0d cycles, want termination after 1", name, n);
        end else begin
            check({name, "_lat"}, 32'(n), 32'd1);
            check({name, "_term"}, {30'b0, wb_ack, wb_err}, {30'b0, !e.err, e.err});
            if (e.chk_dat) check({name, "_dat"}, wb_dat_r, e.dat);
        end
        wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic stream_in(input string name, input logic [31:0] w);
        s_data  = w;
        s_valid = 1'b1;
        check({name, "_sready"}, 32'(s_ready), 32'h1);
        rx_q.push_back(w);
        @(posedge clk); #1;
        s_valid = 1'b0;
    endtask

    task automatic drain_tx(input string name, input int k);
        for (int i = 0; i < k; i++) begin
            check({name, "_mvalid"}, 32'(m_valid), 32'h1);
            if (tx_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL %s_model: got empty model queue, want a pending word", name);
            end else begin
                check({name, "_mdata"}, m_data, tx_q.pop_front());
            end
            m_ready = 1'b1;
            @(posedge clk); #1;
            m_ready = 1'b0;
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got no end of test, want completion within 1 ms");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // ---------------- reset ----------------
        repeat (3) @(posedge clk);
        #1;
        check("rst_ack",    32'(wb_ack),   32'h0);
        check("rst_err",    32'(wb_err),   32'h0);
        check("rst_rty",    32'(wb_rty),   32'h0);
        check("rst_dat",    wb_dat_r,      32'h0);
        check("rst_mvalid", 32'(m_valid),  32'h0);
        check("rst_sready", 32'(s_ready),  32'h0);
`ifdef MBOX_IRQ_EN
        check("rst_irq",    32'(irq),      32'h0);
`endif
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rel_sready", 32'(s_ready), 32'h1);
        check("rel_ack",    32'(wb_ack),  32'h0);
        bus_xfer("st_rst", 1'b0, A_STATUS, 32'h0, 4'hF, 1'b0, 32'h0000_0005);

        // ---------------- register vector table ----------------
        add_vec("scr_rd0",  1'b0, A_SCRATCH,    32'h0,          4'hF, 1'b0, 32'h0);
        add_vec("scr_wr",   1'b1, A_SCRATCH,    32'h1234_5678,  4'hF, 1'b0, 32'h0);
        add_vec("scr_rd1",  1'b0, A_SCRATCH,    32'h0,          4'hF, 1'b0, 32'h1234_5678);
        add_vec("scr_wrbe", 1'b1, A_SCRATCH,    32'hAABB_CCDD,  4'h5, 1'b0, 32'h0);
        add_vec("scr_alias",1'b0, 32'h0000_F00C,32'h0,          4'hF, 1'b0, 32'h12BB_56DD);
        add_vec("st_wr",    1'b1, A_STATUS,     32'hFFFF_FFFF,  4'hF, 1'b1, 32'h0);
        add_vec("st_rd1",   1'b0, A_STATUS,     32'h0,          4'hF, 1'b0, 32'h0000_0005);
        add_vec("dat_sel",  1'b1, A_DATA,       32'h0000_CAFE,  4'h7, 1'b1, 32'h0);
        add_vec("st_rd2",   1'b0, A_STATUS,     32'h0,          4'hF, 1'b0, 32'h0000_0005);
        add_vec("ctl_wrbe", 1'b1, A_CTRL,       32'hFFFF_FFFF,  4'hE, 1'b0, 32'h0);
        add_vec("ctl_rd0",  1'b0, A_CTRL,       32'h0,          4'hF, 1'b0, 32'h0);
        add_vec("ctl_wr3",  1'b1, A_CTRL,       32'h0000_0003,  4'h1, 1'b0, 32'h0);
        add_vec("ctl_rd1",  1'b0, A_CTRL,       32'h0,          4'hF, 1'b0, 32'h1);
        add_vec("ctl_wr0",  1'b1, A_CTRL,       32'h0,          4'hF, 1'b0, 32'h0);
        add_vec("rx_empty", 1'b0, A_DATA,       32'h0,          4'hF, 1'b1, 32'h0);
        add_vec("ctl_rd2",  1'b0, A_CTRL,       32'h0,          4'hF, 1'b0, 32'h0);
        foreach (vecs[i]) begin
            bus_xfer(vecs[i].name, vecs[i].we, vecs[i].adr, vecs[i].dat, vecs[i].sel, vecs[i].err, vecs[i].rdat);
        end

        // ---------------- single TX word ----------------
        bus_xfer("tx_one", 1'b1, A_DATA, 32'hDEAD_BEEF, 4'hF, 1'b0, 32'h0);
        drain_tx("tx_one", 1);
        check("tx_one_gone", 32'(m_valid), 32'h0);

        // ---------------- fill TX, 9th write errors ----------------
        for (int i = 0; i < 9; i++) begin
            bus_xfer("tx_fill", 1'b1, A_DATA, 32'h3000_0000 + i, 4'hF, (i == 8), 32'h0);
        end
        bus_xfer("st_full", 1'b0, A_STATUS, 32'h0, 4'hF, 1'b0, 32'h0000_0806);
        check("tx_head", m_data, 32'h3000_0000);

        // Write while full coincides with a stream pop: still an error, word dropped.
        wb_adr = A_DATA; wb_dat_w = 32'h5555_5555; wb_sel = 4'hF; wb_we = 1'b1;
        wb_cyc = 1'b1; wb_stb = 1'b1; m_ready = 1'b1;
        check("fullpop_mdata", m_data, tx_q.pop_front());
        @(posedge clk); #1;
        check("fullpop_term", {30'b0, wb_ack, wb_err}, 32'h1);
        m_ready = 1'b0; wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
        @(posedge clk); #1;
        bus_xfer("st_seven", 1'b0, A_STATUS, 32'h0, 4'hF, 1'b0, 32'h0000_0704);
        drain_tx("tx_drain", 7);
        check("tx_drained", 32'(m_valid), 32'h0);

        // ---------------- simultaneous push and pop ----------------
        bus_xfer("pp_a", 1'b1, A_DATA, 32'hA5A5_0001, 4'hF, 1'b0, 32'h0);
        tx_q.push_back(32'hA5A5_0002);
        wb_adr = A_DATA; wb_dat_w = 32'hA5A5_0002; wb_sel = 4'hF; wb_we = 1'b1;
        wb_cyc = 1'b1; wb_stb = 1'b1; m_ready = 1'b1;
        check("pp_pop", m_data, tx_q.pop_front());
        @(posedge clk); #1;
        check("pp_term", {30'b0, wb_ack, wb_err}, 32'h2);
        m_ready = 1'b0; wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
        @(posedge clk); #1;
        bus_xfer("st_pp", 1'b0, A_STATUS, 32'h0, 4'hF, 1'b0, 32'h0000_0104);
        drain_tx("pp", 1);

        // ---------------- RX path ----------------
        stream_in("rx_11", 32'h11);
        stream_in("rx_22", 32'h22);
        bus_xfer("st_rx2", 1'b0, A_STATUS, 32'h0, 4'hF, 1'b0, 32'h0002_0001);
        bus_xfer("rx_rd0", 1'b0, A_DATA, 32'h0, 4'hF, 1'b0, rx_q.pop_front());
        bus_xfer("rx_rd1", 1'b0, A_DATA, 32'h0, 4'hF, 1'b0, rx_q.pop_front());
        bus_xfer("rx_rd2", 1'b0, A_DATA, 32'h0, 4'hF, 1'b1, 32'h0);

        for (int i = 0; i < 8; i++) stream_in("rx_fill", 32'h4000_0000 + i);
        check("rx_full_sready", 32'(s_ready), 32'h0);
        bus_xfer("st_rxfull", 1'b0, A_STATUS, 32'h0, 4'hF, 1'b0, 32'h0008_0009);
        bus_xfer("rx_rdfull", 1'b0, A_DATA, 32'h0, 4'hF, 1'b0, rx_q.pop_front());
        check("rx_sready_back", 32'(s_ready), 32'h1);

        // ---------------- flush ----------------
        bus_xfer("flush1", 1'b1, A_CTRL, 32'h2, 4'hF, 1'b0, 32'h0);
        rx_q.delete();
        tx_q.delete();
        bus_xfer("st_flush1", 1'b0, A_STATUS, 32'h0, 4'hF, 1'b0, 32'h0000_0005);
        for (int i = 0; i < 3; i++) bus_xfer("fl_tx", 1'b1, A_DATA, 32'h5000_0000 + i, 4'hF, 1'b0, 32'h0);
        stream_in("fl_rx0", 32'h6000_0000);
        stream_in("fl_rx1", 32'h6000_0001);
        bus_xfer("st_pre", 1'b0, A_STATUS, 32'h0, 4'hF, 1'b0, 32'h0002_0300);
        bus_xfer("flush2", 1'b1, A_CTRL, 32'h2, 4'hF, 1'b0, 32'h0);
        rx_q.delete();
        tx_q.delete();
        bus_xfer("st_flush2", 1'b0, A_STATUS, 32'h0, 4'hF, 1'b0, 32'h0000_0005);
        bus_xfer("ctl_flush", 1'b0, A_CTRL, 32'h0, 4'hF, 1'b0, 32'h0);
        check("flush_mvalid", 32'(m_valid), 32'h0);

`ifdef MBOX_IRQ_EN
        // ---------------- interrupt timing ----------------
        bus_xfer("irq_en", 1'b1, A_CTRL, 32'h1, 4'hF, 1'b0, 32'h0);
        check("irq_idle", 32'(irq), 32'h0);
        stream_in("irq_in", 32'hAB);
        check("irq_hs0", 32'(irq), 32'h0);
        @(posedge clk); #1;
        check("irq_hs1", 32'(irq), 32'h1);
        wb_adr = A_DATA; wb_we = 1'b0; wb_sel = 4'hF; wb_cyc = 1'b1; wb_stb = 1'b1;
        @(posedge clk); #1;
        check("irq_rd_term", {30'b0, wb_ack, wb_err}, 32'h2);
        check("irq_rd_dat", wb_dat_r, rx_q.pop_front());
        check("irq_ack0", 32'(irq), 32'h1);
        wb_cyc = 1'b0; wb_stb = 1'b0;
        @(posedge clk); #1;
        check("irq_ack1", 32'(irq), 32'h0);
`endif

        // ---------------- reset mid-transfer ----------------
        wb_adr = A_DATA; wb_dat_w = 32'h77; wb_sel = 4'hF; wb_we = 1'b1;
        wb_cyc = 1'b1; wb_stb = 1'b1; rst_n = 1'b0;
        @(posedge clk); #1;
        check("mid_ack",    {30'b0, wb_ack, wb_err}, 32'h0);
        check("mid_mvalid", 32'(m_valid), 32'h0);
        check("mid_sready", 32'(s_ready), 32'h0);
        wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("mid_rel_sready", 32'(s_ready), 32'h1);
        tx_q.delete();
        rx_q.delete();
        bus_xfer("mid_st",  1'b0, A_STATUS,  32'h0, 4'hF, 1'b0, 32'h0000_0005);
        bus_xfer("mid_scr", 1'b0, A_SCRATCH, 32'h0, 4'hF, 1'b0, 32'h0);
        bus_xfer("mid_ctl", 1'b0, A_CTRL,    32'h0, 4'hF, 1'b0, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
